// File: rtl/nn_pkg.sv
// Shared types and Q-format helpers for the layer sequencer and its neighbours.
package nn_pkg;

  // Sequencer states.
  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StRun,
    StAcc,
    StDone
  } seq_state_t;

  // Widest word relu_sm() can handle; callers zero-extend into it.
  localparam int unsigned QMaxW = 64;

  // Default Q16.15 sign-magnitude constants (MSB is the sign).
  localparam logic [31:0] Q_ONE     = 32'h0000_8000;
  localparam logic [31:0] Q_MAX_MAG = 32'h7FFF_FFFF;

  // Sign-magnitude ReLU: any word with the sign bit set, negative zero included, becomes 0.
  function automatic logic [QMaxW-1:0] relu_sm(input logic [QMaxW-1:0] x,
                                               input int unsigned width);
    logic [QMaxW-1:0] sign_mask;
    sign_mask = QMaxW'(1) << (width - 1);
    return ((x & sign_mask) != '0) ? '0 : x;
  endfunction

endpackage

// File: rtl/qadd.sv
// Sign-magnitude adder; magnitudes past full scale saturate with the sign kept.
module qadd #(
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] a_i,
  input  logic [N-1:0] b_i,
  output logic [N-1:0] sum_o
);

  logic [N-1:0] mag_a;
  logic [N-1:0] mag_b;
  logic [N-1:0] mag;
  logic         sign;

  // Add or subtract magnitudes depending on sign agreement, then saturate.
  always_comb begin
    mag_a = {1'b0, a_i[N-2:0]};
    mag_b = {1'b0, b_i[N-2:0]};
    if (a_i[N-1] == b_i[N-1]) begin
      mag  = mag_a + mag_b;
      sign = a_i[N-1];
    end else if (mag_a > mag_b) begin
      mag  = mag_a - mag_b;
      sign = a_i[N-1];
    end else begin
      mag  = mag_b - mag_a;
      // Exact cancellation yields +0, never -0.
      sign = (mag != '0) ? b_i[N-1] : 1'b0;
    end
    if (mag[N-1]) begin
      sum_o = {sign, {(N-1){1'b1}}};
    end else begin
      sum_o = {sign, mag[N-2:0]};
    end
  end

endmodule

// File: rtl/dot_layer_sequencer.sv
// Walks the rows of one fully-connected layer through a shared dot-product unit,
// adds the bias, optionally applies ReLU and writes each neuron to the output buffer.
module dot_layer_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned FRACTION_WIDTH = 15,
  parameter int unsigned BIT_WIDTH      = 32,
  parameter int unsigned NUM_ROWS       = 10,
  parameter int unsigned RELU_EN        = 1,
  parameter int unsigned WATCHDOG       = 255,
  localparam int unsigned RowW          = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [RowW-1:0]      row_addr_o,
  input  logic [BIT_WIDTH-1:0] bias_in_i,
  output logic                 dot_start_o,
  input  logic                 dot_done_i,
  input  logic [BIT_WIDTH-1:0] dot_result_i,
  output logic                 out_we_o,
  output logic [RowW-1:0]      out_addr_o,
  output logic [BIT_WIDTH-1:0] out_data_o
);

  localparam int unsigned WdW = $clog2(WATCHDOG + 1);
  localparam logic [RowW-1:0] LastRow = RowW'(NUM_ROWS - 1);

  // Reject parameter sets the datapath cannot represent.
  if (FRACTION_WIDTH >= BIT_WIDTH || BIT_WIDTH > QMaxW || NUM_ROWS < 1 || WATCHDOG < 1)
  begin : g_bad_params
    $error("dot_layer_sequencer: unsupported parameter combination");
  end

  seq_state_t           state_q;
  logic [RowW-1:0]      row_q;
  logic [RowW-1:0]      out_addr_q;
  logic [WdW-1:0]       wdog_q;
  logic [WdW-1:0]       wdog_inc;
  logic                 dot_start_q;
  logic                 out_we_q;
  logic                 done_q;
  logic                 err_q;
  logic [BIT_WIDTH-1:0] out_data_q;
  logic [BIT_WIDTH-1:0] sum;
  logic [BIT_WIDTH-1:0] act;

  qadd #(
    .N(BIT_WIDTH)
  ) u_qadd (
    .a_i  (dot_result_i),
    .b_i  (bias_in_i),
    .sum_o(sum)
  );

  assign act      = (RELU_EN != 0) ? BIT_WIDTH'(relu_sm(QMaxW'(sum), BIT_WIDTH)) : sum;
  assign wdog_inc = wdog_q + WdW'(1);

  // Layer FSM with the row and watchdog counters and all registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= StIdle;
      row_q       <= '0;
      out_addr_q  <= '0;
      wdog_q      <= '0;
      dot_start_q <= 1'b0;
      out_we_q    <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      out_data_q  <= '0;
    end else begin
      out_we_q <= 1'b0;
      done_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            row_q   <= '0;
            err_q   <= 1'b0;
            state_q <= StFetch;
          end
        end
        StFetch: begin
          // A done still high from the previous row must clear before restarting.
          if (!dot_done_i) begin
            wdog_q      <= '0;
            dot_start_q <= 1'b1;
            state_q     <= StRun;
          end
        end
        StRun: begin
          // Completion wins over a watchdog expiring in the same cycle.
          if (dot_done_i) begin
            dot_start_q <= 1'b0;
            out_we_q    <= 1'b1;
            out_addr_q  <= row_q;
            out_data_q  <= act;
            state_q     <= StAcc;
          end else if (wdog_inc == WdW'(WATCHDOG)) begin
            dot_start_q <= 1'b0;
            err_q       <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= StDone;
          end else begin
            wdog_q <= wdog_inc;
          end
        end
        StAcc: begin
          if (row_q == LastRow) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            row_q   <= row_q + RowW'(1);
            state_q <= StFetch;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o      = (state_q != StIdle);
  assign done_o      = done_q;
  assign err_o       = err_q;
  assign row_addr_o  = row_q;
  assign dot_start_o = dot_start_q;
  assign out_we_o    = out_we_q;
  assign out_addr_o  = out_addr_q;
  assign out_data_o  = out_data_q;

endmodule
